contador_vai_vem_modo: RTL
==========================

# contador_vai_vem_modo

Parametrised up/down counter that generalises the manual vai/vem counter. It adds a variable step, three counting modes (saturating, cyclic wrap-around, automatic ping-pong), synchronous parallel load, a direction register and a registered overflow/bounce pulse. It sits in the datapath wherever a bounded position or index is stepped by FSM commands, for example position or timing sweeps and menu cursors.

## Interface
- M, default 100: modulus; legal values are 0..M-1; M >= 2.
- N, default 7: width of Q and D; 2^N >= M is required.
- S, default 7: width of passo.
- clock  in  1  rising-edge clock.
- zera_as  in  1  asynchronous reset, active-high.
- zera_s  in  1  synchronous clear.
- carrega  in  1  synchronous load of D.
- D  in  N  load value.
- modo  in  2  00 saturating, 01 cyclic, 10 ping-pong, 11 hold.
- vai  in  1  step up (modes 00/01).
- vem  in  1  step down (modes 00/01).
- conta  in  1  step enable in mode 10.
- passo  in  S  step size.
- Q  out  N  count.
- sentido  out  1  direction register: 1 = up, 0 = down.
- estouro  out  1  registered one-cycle event pulse.
- fim  out  1  Q == M-1.
- meio  out  1  Q == M/2-1 (integer division).
- inicio  out  1  Q == 0.

One clock; reset is asynchronous and active-high.

## Operation
- Priority at each edge: zera_s > carrega > mode action.
- zera_s: Q=0, sentido=1, estouro=0.
- carrega: Q = min(D, M-1). sentido is unchanged. estouro=0.
- Effective step p = min(passo, M-1). If p == 0, Q holds and no estouro is raised.
- Arithmetic is done in N+1 bits, so Q+p never overflows internally.
- Mode 00 (saturating):
  - vai only: Q = min(Q+p, M-1).
  - vem only: Q = max(Q-p, 0).
  - estouro=1 if the requested step was clamped, including a step requested while Q is already at the bound.
- Mode 01 (cyclic):
  - vai: if Q+p > M-1 then Q = Q+p-M, else Q = Q+p.
  - vem: if Q < p then Q = Q+M-p, else Q = Q-p.
  - estouro=1 on every wrap.
- Modes 00/01 with vai and vem both high, or both low: Q holds, estouro=0. vai/vem never modify sentido, and conta is ignored.
- Mode 10 (ping-pong FSM, states SUBINDO (sentido=1) and DESCENDO (sentido=0)); acts only when conta=1, and vai/vem are ignored:
  - SUBINDO: if Q+p >= M-1 then Q=M-1, go to DESCENDO, estouro=1. Otherwise Q=Q+p.
  - DESCENDO: if Q <= p then Q=0, go to SUBINDO, estouro=1. Otherwise Q=Q-p.
  - conta=0: Q and sentido hold.
- Mode 11: Q and sentido hold; estouro=0.
- A modo change takes effect at the next edge. sentido persists across mode changes, so re-entering mode 10 resumes in the stored direction.
- fim, meio and inicio are combinational decodes of Q only.

## Timing
- zera_as=1: Q=0, sentido=1, estouro=0 immediately, independent of clock; all inputs are ignored while it is asserted. Consequently fim=0, inicio=1, and meio=1 only if M/2-1 == 0.
- Q, sentido and estouro update on the same rising edge. estouro is high for exactly the one cycle following the event edge.
- Back-to-back events (for example continuous wrapping) produce back-to-back estouro pulses.
- Decode outputs follow Q with zero added cycles.
- Reset assertion mid-operation aborts any step; the first edge after release acts normally.

## Test plan
Bench parameters: M=10, N=4, S=4.
- Reset: pulse zera_as between clock edges -> Q=0, sentido=1, estouro=0, inicio=1, immediately and without waiting for a clock edge.
- Saturating: modo=00, passo=3, vai for 4 cycles from 0 -> Q=3,6,9,9; estouro high only after the 4th edge; fim=1 from Q=9. Then vem with passo=4 from 9 -> 5,1,0,0; estouro after the edges producing 0 (clamped step) and the following 0.
- Cyclic: modo=01, passo=3, Q=8, vai -> Q=1 with an estouro pulse. Then vem from 1 -> Q=8 with an estouro pulse. passo=12 (clamped to 9) with vai from 1 -> Q=0.
- Ping-pong: modo=10, passo=4, conta=1 from Q=0 -> 4,8,9(sentido=0, estouro),5,1,0(sentido=1, estouro),4. With conta=0 for 2 cycles mid-sweep, Q holds.
- Priority and conflict:
  - zera_s, carrega (D=7) and vai all high -> Q=0.
  - carrega with D=15 -> Q=9.
  - modo=00 with vai=vem=1 -> Q unchanged.
  - modo=11 with vai=1 -> Q unchanged.
- Decodes: load D=4 -> meio=1; passo=0 with vai -> Q stays 4, no estouro.

Source files
------------

// File: rtl/contador_vai_vem_modo.sv
// Bounded up/down counter with variable step and saturating, cyclic and ping-pong modes.
// Ping-pong direction is held in a two-state FSM; estouro flags clamp, wrap and bounce events.
module contador_vai_vem_modo #(
    parameter int unsigned M = 100,
    parameter int unsigned N = 7,
    parameter int unsigned S = 7
) (
    input  logic         clock,
    input  logic         zera_as,
    input  logic         zera_s,
    input  logic         carrega,
    input  logic [N-1:0] D,
    input  logic [1:0]   modo,
    input  logic         vai,
    input  logic         vem,
    input  logic         conta,
    input  logic [S-1:0] passo,
    output logic [N-1:0] Q,
    output logic         sentido,
    output logic         estouro,
    output logic         fim,
    output logic         meio,
    output logic         inicio
);

    // One extra bit so Q+p and Q+M-p never overflow.
    localparam int unsigned W = N + 1;
    localparam logic [W-1:0] MAX_Q  = W'(M - 1);
    localparam logic [W-1:0] MOD_Q  = W'(M);
    localparam logic [N-1:0] FIM_Q  = N'(M - 1);
    localparam logic [N-1:0] MEIO_Q = N'(M / 2 - 1);

    localparam logic [1:0] MODO_SATURA = 2'b00;
    localparam logic [1:0] MODO_CICLO  = 2'b01;
    localparam logic [1:0] MODO_PINGUE = 2'b10;

    typedef enum logic {
        DESCENDO = 1'b0,
        SUBINDO  = 1'b1
    } estado_t;

    estado_t      estado, estado_nxt;
    logic [N-1:0] q_r, q_nxt;
    logic         estouro_r, estouro_nxt;

    logic [W-1:0] q_ext;
    logic [W-1:0] p_ext;
    logic [W-1:0] d_ext;
    logic [W-1:0] soma;
    logic         so_vai;
    logic         so_vem;

    // Effective step is clamped to M-1.
    always_comb begin
        if (32'(passo) > (M - 1)) begin
            p_ext = MAX_Q;
        end else begin
            p_ext = W'(passo);
        end
    end

    assign q_ext  = W'(q_r);
    assign d_ext  = W'(D);
    assign soma   = q_ext + p_ext;
    assign so_vai = vai & ~vem;
    assign so_vem = vem & ~vai;

    always_ff @(posedge clock or posedge zera_as) begin
        if (zera_as) begin
            estado    <= SUBINDO;
            q_r       <= '0;
            estouro_r <= 1'b0;
        end else begin
            estado    <= estado_nxt;
            q_r       <= q_nxt;
            estouro_r <= estouro_nxt;
        end
    end

    // Next count, direction and event; clear beats load beats the mode action.
    always_comb begin
        estado_nxt  = estado;
        q_nxt       = q_r;
        estouro_nxt = 1'b0;

        if (zera_s) begin
            q_nxt      = '0;
            estado_nxt = SUBINDO;
        end else if (carrega) begin
            if (d_ext > MAX_Q) begin
                q_nxt = FIM_Q;
            end else begin
                q_nxt = D;
            end
        end else if (p_ext != '0) begin
            case (modo)
                MODO_SATURA: begin
                    if (so_vai) begin
                        if (soma > MAX_Q) begin
                            q_nxt       = FIM_Q;
                            estouro_nxt = 1'b1;
                        end else begin
                            q_nxt = N'(soma);
                        end
                    end else if (so_vem) begin
                        if (q_ext < p_ext) begin
                            q_nxt       = '0;
                            estouro_nxt = 1'b1;
                        end else begin
                            q_nxt = N'(q_ext - p_ext);
                        end
                    end
                end
                MODO_CICLO: begin
                    if (so_vai) begin
                        if (soma > MAX_Q) begin
                            q_nxt       = N'(soma - MOD_Q);
                            estouro_nxt = 1'b1;
                        end else begin
                            q_nxt = N'(soma);
                        end
                    end else if (so_vem) begin
                        if (q_ext < p_ext) begin
                            q_nxt       = N'(q_ext + MOD_Q - p_ext);
                            estouro_nxt = 1'b1;
                        end else begin
                            q_nxt = N'(q_ext - p_ext);
                        end
                    end
                end
                MODO_PINGUE: begin
                    if (conta) begin
                        case (estado)
                            SUBINDO: begin
                                if (soma >= MAX_Q) begin
                                    q_nxt       = FIM_Q;
                                    estado_nxt  = DESCENDO;
                                    estouro_nxt = 1'b1;
                                end else begin
                                    q_nxt = N'(soma);
                                end
                            end
                            default: begin
                                if (q_ext <= p_ext) begin
                                    q_nxt       = '0;
                                    estado_nxt  = SUBINDO;
                                    estouro_nxt = 1'b1;
                                end else begin
                                    q_nxt = N'(q_ext - p_ext);
                                end
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign Q       = q_r;
    assign sentido = (estado == SUBINDO);
    assign estouro = estouro_r;

    // Position decodes follow Q directly.
    assign fim    = (q_r == FIM_Q);
    assign meio   = (q_r == MEIO_Q);
    assign inicio = (q_r == '0);

endmodule
